command_sequencer: RTL and testbench

Buffers 12-bit ALU commands from an upstream source and issues them one at a time to the ALU controller. Each issue drives the controller's `command` input and pulses its `run` (syscall) input, with a guaranteed minimum spacing between pulses so that each operation completes through the A/B operand registers and the ALU before the next one starts. The block sits directly upstream of the controller, replacing a free-running `command`/`run` source with a queued, flow-controlled one.

---
 rtl/command_sequencer.sv | 125 ++++++++++++
 tb/tb_command_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_sequencer.sv
// command_sequencer: queues ALU commands and issues them to the controller with a fixed run spacing.
// Define CMD_SEQ_STATS_EN to add the issued_count statistics output.
module command_sequencer #(
   parameter int DEPTH     = 8,
   parameter int CMD_W     = 12,
   parameter int ISSUE_GAP = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [CMD_W-1:0]       in_cmd,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   hold,
   input  logic                   flush,
   output logic [CMD_W-1:0]       command,
   output logic                   run,
   output logic [$clog2(DEPTH):0] count,
`ifdef CMD_SEQ_STATS_EN
   output logic [15:0]            issued_count,
`endif
   output logic                   busy
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int GW = $clog2(ISSUE_GAP);
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);
   localparam logic [GW-1:0] GAP_LOAD = GW'(ISSUE_GAP - 2);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t           r_state, w_state_nxt;
   logic [GW-1:0]    r_gap, w_gap_nxt;
   logic [CMD_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [CMD_W-1:0] r_command;
   logic             r_run;
   logic             w_push, w_pop, w_can_issue;

   assign in_ready    = (r_count < FULL) & ~flush;
   assign w_push      = in_valid & in_ready;
   assign w_can_issue = (r_count != '0) & ~hold;

   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap;
      w_pop       = 1'b0;
      if (flush) begin
         w_state_nxt = S_IDLE;
         w_gap_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_nxt = w_can_issue ? S_ISSUE : S_IDLE;
               w_pop       = w_can_issue;
            end
            S_ISSUE: begin
               w_state_nxt = S_WAIT;
               w_gap_nxt   = GAP_LOAD;
            end
            S_WAIT: begin
               w_gap_nxt   = (r_gap != '0) ? r_gap - 1'b1 : r_gap;
               w_state_nxt = (r_gap != '0) ? S_WAIT : (w_can_issue ? S_ISSUE : S_IDLE);
               w_pop       = (r_gap == '0) & w_can_issue;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_gap   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gap   <= w_gap_nxt;
      end
   end

   // Storage carries no reset; occupancy alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= in_cmd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_command <= '0;
         r_run     <= 1'b0;
      end else begin
         r_run <= (w_state_nxt == S_ISSUE);
         if (w_pop) r_command <= r_mem[r_rd_ptr];
         if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push & ~w_pop) r_count <= r_count + 1'b1;
            else if (w_pop & ~w_push) r_count <= r_count - 1'b1;
         end
      end
   end

`ifdef CMD_SEQ_STATS_EN
   logic [15:0] r_issued;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_issued <= '0;
      else if (flush) r_issued <= '0;
      else if (r_run) r_issued <= r_issued + 16'd1;
   end

   assign issued_count = r_issued;
`endif

   assign command = r_command;
   assign run     = r_run;
   assign count   = r_count;
   assign busy    = (r_state != S_IDLE) | (r_count != '0);
endmodule

// File: tb/tb_command_sequencer.sv
// tb_command_sequencer: directed vector table plus hand sequences for hold, full/wrap, flush and reset.
module tb_command_sequencer;
   localparam int DEPTH = 8;
   localparam int CMD_W = 12;
   localparam int GAP   = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [CMD_W-1:0] in_cmd = '0;
   logic             in_valid = 1'b0;
   logic             hold = 1'b0;
   logic             flush = 1'b0;
   logic             in_ready, run, busy;
   logic [CMD_W-1:0] command;
   logic [CNT_W-1:0] count;
`ifdef CMD_SEQ_STATS_EN
   logic [15:0]      issued_count;
`endif

   int n_tests = 0, n_fail = 0, n_issued = 0;
   int k, acc, bad, base;
   logic take;

   always #5 clk = ~clk;

   command_sequencer #(.DEPTH(DEPTH), .CMD_W(CMD_W), .ISSUE_GAP(GAP)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_cmd(in_cmd),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .hold(hold),
      .flush(flush),
      .command(command),
      .run(run),
      .count(count),
`ifdef CMD_SEQ_STATS_EN
      .issued_count(issued_count),
`endif
      .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every accepted push must come out on a run pulse, in order.
   logic [CMD_W-1:0] q[$];
   int since = GAP;

   always @(posedge clk) begin
      if (!rst_n) begin
         q.delete();
         since = GAP;
      end else begin
         chk("in_ready", in_ready, 32'(!flush && q.size() < DEPTH));
         if (flush) q.delete();
         else if (in_valid && q.size() < DEPTH) q.push_back(in_cmd);
         since++;
         #1;
         if (run) begin
            chk("run_spacing", 32'(since >= GAP), 1);
            chk("run_has_entry", 32'(q.size() != 0), 1);
            if (q.size() != 0) chk("run_cmd", command, q.pop_front());
            n_issued++;
            since = 0;
         end
      end
   end

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while ((busy || q.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(n < 200), 1);
   endtask

   typedef struct {
      logic             valid;
      logic [CMD_W-1:0] cmd;
      logic             hold;
      logic             e_run;
      logic [CMD_W-1:0] e_cmd;
      logic [CNT_W-1:0] e_count;
      logic             e_rdy;
      logic             e_busy;
   } vec_t;

   vec_t v[21];

   initial begin
      v[0]  = '{1'b1, 12'h0A5, 1'b0, 1'b0, 12'h000, 4'd1, 1'b1, 1'b1};
      v[1]  = '{1'b0, 12'h000, 1'b0, 1'b1, 12'h0A5, 4'd0, 1'b1, 1'b1};
      v[2]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h0A5, 4'd0, 1'b1, 1'b1};
      v[3]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h0A5, 4'd0, 1'b1, 1'b1};
      v[4]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h0A5, 4'd0, 1'b1, 1'b1};
      v[5]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h0A5, 4'd0, 1'b1, 1'b0};
      v[6]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h0A5, 4'd0, 1'b1, 1'b0};
      v[7]  = '{1'b1, 12'h001, 1'b0, 1'b0, 12'h0A5, 4'd1, 1'b1, 1'b1};
      v[8]  = '{1'b1, 12'h002, 1'b0, 1'b1, 12'h001, 4'd1, 1'b1, 1'b1};
      v[9]  = '{1'b1, 12'h003, 1'b0, 1'b0, 12'h001, 4'd2, 1'b1, 1'b1};
      v[10] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h001, 4'd2, 1'b1, 1'b1};
      v[11] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h001, 4'd2, 1'b1, 1'b1};
      v[12] = '{1'b0, 12'h000, 1'b0, 1'b1, 12'h002, 4'd1, 1'b1, 1'b1};
      v[13] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h002, 4'd1, 1'b1, 1'b1};
      v[14] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h002, 4'd1, 1'b1, 1'b1};
      v[15] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h002, 4'd1, 1'b1, 1'b1};
      v[16] = '{1'b0, 12'h000, 1'b0, 1'b1, 12'h003, 4'd0, 1'b1, 1'b1};
      v[17] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h003, 4'd0, 1'b1, 1'b1};
      v[18] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h003, 4'd0, 1'b1, 1'b1};
      v[19] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h003, 4'd0, 1'b1, 1'b1};
      v[20] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h003, 4'd0, 1'b1, 1'b0};

      #12;
      chk("reset_command", command, 0);
      chk("reset_run", run, 0);
      chk("reset_count", count, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         in_valid = v[i].valid;
         in_cmd   = v[i].cmd;
         hold     = v[i].hold;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_run", i), run, v[i].e_run);
         chk($sformatf("v%0d_command", i), command, v[i].e_cmd);
         chk($sformatf("v%0d_count", i), count, v[i].e_count);
         chk($sformatf("v%0d_in_ready", i), in_ready, v[i].e_rdy);
         chk($sformatf("v%0d_busy", i), busy, v[i].e_busy);
      end

      // Hold raised during WAIT: WAIT finishes into IDLE, no issue until release.
      @(negedge clk); in_valid = 1'b1; in_cmd = 12'h2A1;
      @(negedge clk); in_valid = 1'b0;
      @(posedge clk); #1;
      chk("hold_first_run", run, 1);
      chk("hold_first_cmd", command, 12'h2A1);
      @(negedge clk); hold = 1'b1; in_valid = 1'b1; in_cmd = 12'h2A2;
      @(negedge clk); in_valid = 1'b0;
      bad = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (run) bad++;
      end
      chk("hold_no_run", bad, 0);
      chk("hold_count", count, 1);
      chk("hold_busy", busy, 1);
      @(negedge clk); hold = 1'b0;
      @(posedge clk); #1;
      chk("hold_release_run", run, 1);
      chk("hold_release_cmd", command, 12'h2A2);
      wait_idle("hold_drain");

      // Fill to full under hold, reject a 9th, then drain across the pointer wrap.
      base = n_issued;
      @(negedge clk); hold = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_cmd   = CMD_W'(12'h100 + i);
         @(negedge clk);
      end
      in_cmd = 12'h1FF;
      #1;
      chk("full_count", count, 8);
      chk("full_in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("full_reject_count", count, 8);
      @(negedge clk);
      hold = 1'b0;
      acc = 0;
      k = 0;
      while (acc < 4 && k < 100) begin
         in_valid = 1'b1;
         in_cmd   = CMD_W'(12'h108 + acc);
         #1 take = in_ready;
         @(posedge clk);
         if (take) acc++;
         k++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("wrap_pushes", acc, 4);
      wait_idle("wrap_drain");
      chk("wrap_issued", n_issued - base, 12);

      // Flush during ISSUE with a push offered in the same cycle.
      @(negedge clk); hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_cmd   = CMD_W'(12'h301 + i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      hold = 1'b0;
      @(posedge clk); #1;
      chk("flush_pre_run", run, 1);
      chk("flush_pre_count", count, 3);
      @(negedge clk); flush = 1'b1; in_valid = 1'b1; in_cmd = 12'h3FF;
      #1 chk("flush_in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("flush_run", run, 0);
      chk("flush_count", count, 0);
      chk("flush_busy", busy, 0);
      chk("flush_command", command, 12'h301);
`ifdef CMD_SEQ_STATS_EN
      chk("flush_stats", issued_count, 0);
`endif
      @(negedge clk); flush = 1'b0; in_valid = 1'b0;
      bad = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (run || count != 0) bad++;
      end
      chk("flush_discarded", bad, 0);

`ifdef CMD_SEQ_STATS_EN
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_cmd   = CMD_W'(12'h401 + i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      wait_idle("stats_drain");
      chk("stats_five", issued_count, 5);
`endif

      // Asynchronous reset while in WAIT with entries still queued.
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_cmd   = CMD_W'(12'h501 + i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      k = 0;
      while (!run && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk("rst_run_seen", run, 1);
      @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_command", command, 0);
      chk("arst_run", run, 0);
      chk("arst_count", count, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_busy", busy, 0);
`ifdef CMD_SEQ_STATS_EN
      chk("arst_stats", issued_count, 0);
`endif
      @(negedge clk); rst_n = 1'b1;
      bad = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (run || count != 0) bad++;
      end
      chk("arst_queue_lost", bad, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
